uart_sample_rx: RTL and testbench

Serial receiver that turns the 8N1 byte stream arriving on the JB1 pin into an 8-bit sample register. It sits directly upstream of the PWM comparator and takes the place of the internal sine table as its reference input. The held `sample` output is a level the comparator reads every clock. `sample_valid` marks each new byte.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sample_rx_sync_2ff.sv | 25 ++
 rtl/uart_sample_rx.sv | 150 +++++++++++++++
 tb/tb_uart_sample_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART sample receiver.
// The ST_PARITY encoding is only reached when UART_SAMPLE_RX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   typedef struct packed {
      logic [31:0] div;
      logic [31:0] half;
   } baud_cfg_t;

   localparam logic [7:0] SAMPLE_RST = 8'h80;

   function automatic baud_cfg_t baud_cfg(input int unsigned clk_hz, input int unsigned baud);
      baud_cfg_t c;
      c.div  = clk_hz / baud;
      c.half = c.div / 2;
      return c;
   endfunction

endpackage

// File: rtl/uart_sample_rx_sync_2ff.sv
// 1-bit two-flop synchronizer resetting to 1 (idle level of a UART line).
// Generic enough to be reused for other asynchronous pins.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver producing a held 8-bit sample for the PWM comparator.
// Define UART_SAMPLE_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_sample_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] sample,
   output logic       sample_valid,
   output logic       frame_err
);

   localparam baud_cfg_t   CFG   = baud_cfg(CLK_HZ, BAUD);
   localparam int unsigned DIV   = CFG.div;
   localparam int unsigned HALF  = CFG.half;
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

   logic             rx_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       sample_q, sample_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             frame_ok;
`ifdef UART_SAMPLE_RX_PARITY_EN
   logic             par_err_q, par_err_d;
`endif

   sync_2ff u_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (rx),
      .q_o   (rx_s)
   );

`ifdef UART_SAMPLE_RX_PARITY_EN
   assign frame_ok = rx_s & ~par_err_q;
`else
   assign frame_ok = rx_s;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
`ifdef UART_SAMPLE_RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
               bit_d   = '0;
            end
         end
         ST_START: begin
            // Mid-start-bit recheck rejects glitches shorter than half a bit.
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (cnt_q == DIV_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_SAMPLE_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_SAMPLE_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == DIV_M1) begin
               cnt_d     = '0;
               par_err_d = ^{shift_q, rx_s};
               state_d   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Leave mid-stop-bit so back-to-back frames are not missed.
            if (cnt_q == DIV_M1) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (frame_ok) begin
                  sample_d = shift_q;
                  valid_d  = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         sample_q <= SAMPLE_RST;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
`ifdef UART_SAMPLE_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
`ifdef UART_SAMPLE_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_sample_rx.sv
// Directed self-checking bench for uart_sample_rx at CLK_HZ=16, BAUD=1 (DIV=16, HALF=8).
module tb_uart_sample_rx;

`ifdef UART_SAMPLE_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // pin edge -> rx_s low (2) + HALF + (NB-1) bit periods + 1 output register
   localparam int PULSE_OFF = 2 + 8 + (NB - 1) * 16 + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] sample;
   logic       sample_valid;
   logic       frame_err;

   int cyc = 0;
   int n_valid = 0, n_ferr = 0, n_both = 0;
   int last_valid = -1, last_ferr = -1;
   int checks = 0, passes = 0, fails = 0;
   int s, s1, s2, v0, f0, vc1;

   uart_sample_rx #(.CLK_HZ(16), .BAUD(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .sample       (sample),
      .sample_valid (sample_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sample_valid) begin
         n_valid++;
         last_valid = cyc;
      end
      if (frame_err) begin
         n_ferr++;
         last_ferr = cyc;
      end
      if (sample_valid && frame_err) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sends the first nbits of a frame; start returns the cycle of the start edge.
   task automatic send_n(input logic [7:0] d, input logic stop, input logic par,
                         input int nbits, output int start);
      logic [10:0] bits;
`ifdef UART_SAMPLE_RX_PARITY_EN
      bits = {stop, par, d, 1'b0};
`else
      bits = {par, stop, d, 1'b0};
`endif
      start = 0;
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk);
         #1 rx = bits[i];
         if (i == 0) start = cyc;
         repeat (15) @(posedge clk);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input logic par, output int start);
      send_n(d, stop, par, NB, start);
   endtask

   task automatic idle(input int n);
      #1 rx = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_sample", sample, 8'h80);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      repeat (200) @(posedge clk);
      check("idle_no_valid", n_valid, 0);
      check("idle_no_ferr", n_ferr, 0);

      // Framing error: 0x55 with stop bit 0
      v0 = n_valid; f0 = n_ferr;
      send(8'h55, 1'b0, ^8'h55, s);
      check("ferr_count", n_ferr, f0 + 1);
      check("ferr_cycle", last_ferr, s + PULSE_OFF);
      check("ferr_no_valid", n_valid, v0);
      check("ferr_sample_kept", sample, 8'h80);
      idle(40);
      check("ferr_tail_ferr", n_ferr, f0 + 1);
      check("ferr_tail_valid", n_valid, v0);

      // Single frame 0xA5
      v0 = n_valid; f0 = n_ferr;
      send(8'hA5, 1'b1, ^8'hA5, s);
      check("a5_count", n_valid, v0 + 1);
      check("a5_cycle", last_valid, s + PULSE_OFF);
      check("a5_sample", sample, 8'hA5);
      check("a5_no_ferr", n_ferr, f0);
      idle(20);

      // Back-to-back 0x00 then 0xFF
      v0 = n_valid;
      send(8'h00, 1'b1, ^8'h00, s1);
      vc1 = last_valid;
      check("b2b_first_cycle", vc1, s1 + PULSE_OFF);
      check("b2b_first_sample", sample, 8'h00);
      send(8'hFF, 1'b1, ^8'hFF, s2);
      check("b2b_count", n_valid, v0 + 2);
      check("b2b_spacing", last_valid - vc1, NB * 16);
      check("b2b_sample", sample, 8'hFF);
      idle(20);

      // Glitch: rx low for 3 cycles, then 0x3C
      v0 = n_valid; f0 = n_ferr;
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      check("glitch_no_valid", n_valid, v0);
      check("glitch_no_ferr", n_ferr, f0);
      check("glitch_sample", sample, 8'hFF);
      send(8'h3C, 1'b1, ^8'h3C, s);
      check("g3c_count", n_valid, v0 + 1);
      check("g3c_cycle", last_valid, s + PULSE_OFF);
      check("g3c_sample", sample, 8'h3C);
      idle(20);

      // Reset pulsed during data bit 4 of 0x12
      v0 = n_valid; f0 = n_ferr;
      send_n(8'h12, 1'b1, ^8'h12, 5, s);
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("midrst_async_sample", sample, 8'h80);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(200);
      check("midrst_no_valid", n_valid, v0);
      check("midrst_no_ferr", n_ferr, f0);
      check("midrst_sample", sample, 8'h80);
      send(8'h12, 1'b1, ^8'h12, s);
      check("r12_count", n_valid, v0 + 1);
      check("r12_cycle", last_valid, s + PULSE_OFF);
      check("r12_sample", sample, 8'h12);
      idle(20);

`ifdef UART_SAMPLE_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so the correct parity bit is 1
      v0 = n_valid; f0 = n_ferr;
      send(8'h07, 1'b1, 1'b0, s);
      check("par_bad_ferr", n_ferr, f0 + 1);
      check("par_bad_cycle", last_ferr, s + PULSE_OFF);
      check("par_bad_sample", sample, 8'h12);
      idle(40);
      send(8'h07, 1'b1, 1'b1, s);
      check("par_ok_count", n_valid, v0 + 1);
      check("par_ok_sample", sample, 8'h07);
      idle(20);
`endif

      check("never_both", n_both, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
